image_frame_sequencer: RTL and testbench

Multi-slot successor to the single-image sender. Accepts 128-bit pixel words from the AXI2FIFO write interface into NUM_SLOTS image slots held in one on-chip RAM. Renders the active slot into the pixel stream at a programmable offset with integer power-of-two upscaling. Advances to the next filled slot on frame boundaries when auto_start is high, so sequences of images can be streamed to the display.

---
 rtl/image_seq_pkg.sv | 27 ++
 rtl/image_slot_ram.sv | 25 ++
 rtl/image_frame_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_image_frame_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_seq_pkg.sv
// Shared constants and helpers for the multi-slot image frame sequencer:
// display states, slot geometry and stored-pixel to rgb conversion.
package image_seq_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    function automatic int calc_ppw(input int din_w, input int pix_bits);
        return din_w / pix_bits;
    endfunction

    function automatic int calc_wpi(input int img_w, input int img_h, input int ppw);
        return (img_w * img_h + ppw - 1) / ppw;
    endfunction

    // 565 channels are widened by replicating their MSBs into the low bits.
    function automatic logic [23:0] pix_to_rgb(input logic [23:0] p, input int pix_bits);
        logic [23:0] c;
        case (pix_bits)
            16:      c = {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
            32:      c = p;
            default: c = {p[7:0], p[7:0], p[7:0]};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/image_slot_ram.sv
// Simple dual-port RAM, one write and one registered read port, holding
// all image slots back to back.
module image_slot_ram #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1250,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/image_frame_sequencer.sv
// Buffers NUM_SLOTS images written as packed words and renders the active one
// into the pixel stream with offset and power-of-two upscaling.
module image_frame_sequencer
    import image_seq_pkg::*;
#(
    parameter int          BIT_WIDTH    = 12,
    parameter int          BIT_HEIGHT   = 11,
    parameter int          IMAGE_WIDTH  = 100,
    parameter int          IMAGE_HEIGHT = 100,
    parameter int          PIXEL_BITS   = 8,
    parameter int          DIN_WIDTH    = 128,
    parameter int          NUM_SLOTS    = 2,
    parameter int          SCALE_BITS   = 2,
    parameter logic [23:0] BG_COLOR     = 24'h000000
) (
    input  logic                         clk_pixel,
    input  logic                         image_sender_reset,
    input  logic                         image_sender_flush,
    input  logic                         image_sender_write,
    input  logic [DIN_WIDTH-1:0]         image_sender_fifo_din,
    output logic                         image_sender_full,
    output logic                         image_sender_empty,
    input  logic                         auto_start,
    input  logic [BIT_WIDTH-1:0]         cx,
    input  logic [BIT_HEIGHT-1:0]        cy,
    input  logic [BIT_WIDTH-1:0]         offset_x,
    input  logic [BIT_HEIGHT-1:0]        offset_y,
    input  logic [SCALE_BITS-1:0]        scale,
    output logic [23:0]                  rgb,
    output logic                         require_new_image,
    output logic [$clog2(NUM_SLOTS)-1:0] active_slot
);

    localparam int PPW    = calc_ppw(DIN_WIDTH, PIXEL_BITS);
    localparam int WPI    = calc_wpi(IMAGE_WIDTH, IMAGE_HEIGHT, PPW);
    localparam int DEPTH  = NUM_SLOTS * WPI;
    localparam int AW     = $clog2(DEPTH);
    localparam int SW     = $clog2(NUM_SLOTS);
    localparam int PTR_W  = (WPI > 1) ? $clog2(WPI) : 1;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

    logic [0:0]           state_q, state_d;
    logic [SW-1:0]        active_slot_q, active_slot_d, next_slot;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [SW-1:0]        wr_slot_q, wr_slot_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic                 req_q, req_d;
    logic                 full_q, empty_q;
    logic                 fs, wr_en;
    logic [AW-1:0]        wr_addr;

    assign fs        = (cx == '0) && (cy == '0);
    assign next_slot = (active_slot_q == SW'(NUM_SLOTS - 1)) ? '0 : active_slot_q + SW'(1);
    // Checking valid[wr_slot] as well covers the cycle before full_q catches up.
    assign wr_en     = image_sender_write && !image_sender_flush && !full_q && !valid_q[wr_slot_q];
    assign wr_addr   = AW'(32'(wr_slot_q) * 32'(WPI) + 32'(wr_ptr_q));

    always_comb begin
        state_d       = state_q;
        active_slot_d = active_slot_q;
        valid_d       = valid_q;
        wr_slot_d     = wr_slot_q;
        wr_ptr_d      = wr_ptr_q;
        req_d         = 1'b0;
        if (state_q == ST_IDLE) begin
            if (fs && auto_start && valid_q[active_slot_q]) begin
                state_d = ST_SHOW;
            end
        end else if (fs && auto_start && valid_q[next_slot]) begin
            valid_d[active_slot_q] = 1'b0;
            req_d                  = 1'b1;
            active_slot_d          = next_slot;
        end
        if (image_sender_flush) begin
            wr_ptr_d = '0;
        end else if (wr_en) begin
            if (wr_ptr_q == PTR_W'(WPI - 1)) begin
                valid_d[wr_slot_q] = 1'b1;
                wr_ptr_d           = '0;
                wr_slot_d          = (wr_slot_q == SW'(NUM_SLOTS - 1)) ? '0 : wr_slot_q + SW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (image_sender_reset) begin
            state_q       <= ST_IDLE;
            active_slot_q <= '0;
            valid_q       <= '0;
            wr_slot_q     <= '0;
            wr_ptr_q      <= '0;
            req_q         <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            active_slot_q <= active_slot_d;
            valid_q       <= valid_d;
            wr_slot_q     <= wr_slot_d;
            wr_ptr_q      <= wr_ptr_d;
            req_q         <= req_d;
            full_q        <= &valid_q;
            empty_q       <= ~|valid_q;
        end
    end

    // Stage 0: window test and RAM word/lane address.
    logic [BIT_WIDTH:0]  dx_full_p0;
    logic [BIT_HEIGHT:0] dy_full_p0;
    logic [31:0]         dx_p0, dy_p0, lim_w_p0, lim_h_p0, lin_p0;
    logic                vld_p0;
    logic [LANE_W-1:0]   lane_p0;
    logic [AW-1:0]       rd_addr_p0;

    always_comb begin
        dx_full_p0 = {1'b0, cx} - {1'b0, offset_x};
        dy_full_p0 = {1'b0, cy} - {1'b0, offset_y};
        dx_p0      = 32'(dx_full_p0[BIT_WIDTH-1:0]);
        dy_p0      = 32'(dy_full_p0[BIT_HEIGHT-1:0]);
        lim_w_p0   = 32'(IMAGE_WIDTH) << scale;
        lim_h_p0   = 32'(IMAGE_HEIGHT) << scale;
        vld_p0     = (state_q == ST_SHOW) && !dx_full_p0[BIT_WIDTH] && !dy_full_p0[BIT_HEIGHT]
                     && (dx_p0 < lim_w_p0) && (dy_p0 < lim_h_p0);
        lin_p0     = (dy_p0 >> scale) * 32'(IMAGE_WIDTH) + (dx_p0 >> scale);
        lane_p0    = LANE_W'(lin_p0 % 32'(PPW));
        rd_addr_p0 = AW'(32'(active_slot_q) * 32'(WPI) + lin_p0 / 32'(PPW));
    end

    // Stage 1: RAM read, lane and window flag delayed alongside.
    logic                 vld_p1_q;
    logic [LANE_W-1:0]    lane_p1_q;
    logic [DIN_WIDTH-1:0] rd_data_p1;
    logic [PIXEL_BITS-1:0] pix_p1;

    image_slot_ram #(
        .DATA_W (DIN_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk_i     (clk_pixel),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (image_sender_fifo_din),
        .rd_addr_i (rd_addr_p0),
        .rd_data_o (rd_data_p1)
    );

    always_ff @(posedge clk_pixel) begin
        if (image_sender_reset) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        lane_p1_q <= lane_p0;
    end

    always_comb begin
        pix_p1 = '0;
        for (int k = 0; k < PPW; k++) begin
            if (lane_p1_q == LANE_W'(k)) begin
                pix_p1 = rd_data_p1[k*PIXEL_BITS +: PIXEL_BITS];
            end
        end
    end

    // Stage 2: colour conversion into the output register.
    logic [23:0] rgb_p2_q;

    always_ff @(posedge clk_pixel) begin
        if (image_sender_reset) begin
            rgb_p2_q <= BG_COLOR;
        end else if (vld_p1_q) begin
            rgb_p2_q <= pix_to_rgb(24'(pix_p1), PIXEL_BITS);
        end else begin
            rgb_p2_q <= BG_COLOR;
        end
    end

    assign rgb                = rgb_p2_q;
    assign require_new_image  = req_q;
    assign active_slot        = active_slot_q;
    assign image_sender_full  = full_q;
    assign image_sender_empty = empty_q;

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Randomized bench for image_frame_sequencer against a pixel-level model of
// slot contents, slot ownership and the display window.
module tb_image_frame_sequencer;

    localparam int IW   = 100;
    localparam int IH   = 100;
    localparam int NS   = 2;
    localparam int WPI  = 625;
    localparam int PPW  = 16;
    localparam int NPIX = IW * IH;
    localparam logic [23:0] BG = 24'h000000;

    logic         clk = 1'b0;
    logic         rst, flush, wr, auto;
    logic [127:0] din;
    logic         full, empty, req;
    logic [11:0]  cx, ox;
    logic [10:0]  cy, oy;
    logic [1:0]   sc;
    logic [23:0]  rgb;
    logic [0:0]   act;

    always #5 clk = ~clk;

    image_frame_sequencer dut (
        .clk_pixel             (clk),
        .image_sender_reset    (rst),
        .image_sender_flush    (flush),
        .image_sender_write    (wr),
        .image_sender_fifo_din (din),
        .image_sender_full     (full),
        .image_sender_empty    (empty),
        .auto_start            (auto),
        .cx                    (cx),
        .cy                    (cy),
        .offset_x              (ox),
        .offset_y              (oy),
        .scale                 (sc),
        .rgb                   (rgb),
        .require_new_image     (req),
        .active_slot           (act)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference state: image contents per slot, slot ownership, display state.
    logic [7:0]    img [NS][NPIX];
    logic [NS-1:0] mvalid;
    int            wslot, wptr, mact;
    bit            mshow, mfull, mempty, mreq;
    logic [23:0]   exp_prev;

    function automatic logic [23:0] model_rgb();
        int dx, dy;
        logic [7:0] p;
        if (!mshow) return BG;
        dx = int'(cx) - int'(ox);
        dy = int'(cy) - int'(oy);
        if (dx < 0 || dy < 0 || dx >= (IW << sc) || dy >= (IH << sc)) return BG;
        p = img[mact][(dy >> sc) * IW + (dx >> sc)];
        return {p, p, p};
    endfunction

    task automatic tick();
        logic [23:0]   e_now;
        logic [NS-1:0] old_valid;
        bit            fs;
        e_now = rst ? BG : model_rgb();
        if (rst) begin
            mvalid = '0; wslot = 0; wptr = 0; mact = 0;
            mshow = 0; mfull = 0; mempty = 1; mreq = 0;
        end else begin
            old_valid = mvalid;
            fs   = (cx == 0) && (cy == 0);
            mreq = 0;
            if (!mshow) begin
                if (fs && auto && old_valid[mact]) mshow = 1;
            end else if (fs && auto && old_valid[(mact + 1) % NS]) begin
                mvalid[mact] = 1'b0;
                mreq = 1;
                mact = (mact + 1) % NS;
            end
            if (flush) begin
                wptr = 0;
            end else if (wr && !mfull) begin
                for (int k = 0; k < PPW; k++) begin
                    int idx;
                    idx = wptr * PPW + k;
                    if (idx < NPIX) img[wslot][idx] = din[k*8 +: 8];
                end
                if (wptr == WPI - 1) begin
                    mvalid[wslot] = 1'b1;
                    wptr  = 0;
                    wslot = (wslot + 1) % NS;
                end else begin
                    wptr++;
                end
            end
            mfull  = &old_valid;
            mempty = ~|old_valid;
        end
        @(posedge clk);
        #1;
        chk("rgb", rgb, rst ? BG : exp_prev);
        chk("full", full, mfull);
        chk("empty", empty, mempty);
        chk("require_new_image", req, mreq);
        chk("active_slot", act, mact);
        exp_prev = e_now;
    endtask

    task automatic rnd_xy();
        cx = 12'($urandom_range(1, 450));
        cy = 11'($urandom_range(0, 450));
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            rnd_xy();
            tick();
        end
    endtask

    task automatic fs_tick();
        cx = '0;
        cy = '0;
        tick();
        rnd_xy();
    endtask

    task automatic wr_words(input int n, input int p0);
        for (int i = 0; i < n; i++) begin
            wr  = 1'b1;
            din = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i == 0 && p0 >= 0) din[7:0] = p0[7:0];
            rnd_xy();
            tick();
        end
        wr = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr = 1'b0; auto = 1'b0; din = '0;
        cx = 12'd5; cy = 11'd5; ox = '0; oy = '0; sc = '0;
        exp_prev = BG;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_rgb", rgb, 24'h000000);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_active", act, 0);

        // Frame start with nothing buffered must stay idle.
        auto = 1'b1;
        fs_tick();
        sweep(5);
        auto = 1'b0;

        // First image into slot 0, pixel 0 = 0x40.
        wr_words(WPI, 'h40);
        chk("t1_empty", empty, 0);
        chk("t1_full", full, 0);

        auto = 1'b1; ox = 12'd10; oy = 11'd20; sc = 2'd0;
        fs_tick();
        cx = 12'd10; cy = 11'd20; tick();
        cx = 12'd9;  tick();
        chk("t2_origin", rgb, 24'h404040);
        cx = 12'd50; tick();
        chk("t2_left_of_window", rgb, BG);
        sweep(200);

        ox = '0; oy = '0; sc = 2'd1;
        cx = 12'd1; cy = 11'd1; tick();
        cx = 12'd0; cy = 11'd0; tick();
        chk("t3_scaled_11", rgb, 24'h404040);
        cx = 12'd199; cy = 11'd3; tick();
        chk("t3_scaled_00", rgb, 24'h404040);
        cx = 12'd200; tick();
        cx = 12'd5; cy = 11'd5; tick();
        chk("t3_right_edge", rgb, BG);
        for (int r = 0; r < 8; r++) begin
            sc = 2'($urandom_range(0, 3));
            ox = 12'($urandom_range(0, 60));
            oy = 11'($urandom_range(0, 60));
            sweep(60);
        end

        // Second image fills the buffer; an extra write must be dropped.
        sc = '0; ox = '0; oy = '0;
        wr_words(WPI, -1);
        chk("t4_full", full, 1);
        wr_words(1, -1);
        auto = 1'b0;
        fs_tick();
        chk("t4_hold_active", act, 0);
        auto = 1'b1;
        fs_tick();
        chk("t4_req_pulse", req, 1);
        chk("t4_active", act, 1);
        tick();
        chk("t4_req_single", req, 0);
        chk("t4_full_clear", full, 0);
        sweep(100);
        wr_words(WPI, -1);
        fs_tick();
        sweep(200);

        // Partial image discarded by flush, flush wins over a same-cycle write.
        wr_words(300, -1);
        flush = 1'b1; wr = 1'b1; din = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        flush = 1'b0; wr = 1'b0;
        tick();
        wr_words(WPI, 'h5A);
        fs_tick();
        chk("t5_active", act, 1);
        ox = 12'd5; oy = 11'd5;
        cx = 12'd5; cy = 11'd5; tick();
        tick();
        chk("t5_first_pixel", rgb, 24'h5A5A5A);
        sweep(150);

        // Reset while displaying, at a frame start that would otherwise advance.
        wr_words(WPI, -1);
        chk("t6_full", full, 1);
        rst = 1'b1; cx = '0; cy = '0;
        tick();
        chk("t6_rgb", rgb, BG);
        chk("t6_empty", empty, 1);
        chk("t6_req", req, 0);
        chk("t6_active", act, 0);
        rst = 1'b0;
        rnd_xy();
        tick();
        chk("t6_rgb_after", rgb, BG);
        fs_tick();
        sweep(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
